// File: rtl/tx_arbiter.sv
// Two-requester arbiter for a serial link: header chunks then payload.
// Optional macro TX_ARB_ROUND_ROBIN_EN alternates grants when both eligible.
module tx_arbiter #(
    parameter int NSHIFT         = 2,
    parameter int CMD_BITS       = 4,
    parameter int PAYLOAD_CYCLES = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sched_valid,
    input  logic                              sched_reserve,
    input  logic [CMD_BITS-1:0]               sched_cmd,
    input  logic [NSHIFT-1:0]                 sched_data,
    input  logic                              pf_valid,
    input  logic [CMD_BITS-1:0]               pf_cmd,
    input  logic [NSHIFT-1:0]                 pf_data,
    output logic                              sched_started,
    output logic                              pf_started,
    output logic                              sched_data_next,
    output logic                              pf_data_next,
    output logic [$clog2(PAYLOAD_CYCLES):0]   tx_counter,
    output logic                              tx_active,
    output logic                              tx_done,
    output logic                              tx_owner,
    output logic [NSHIFT-1:0]                 tx_pins
);

    localparam int HEADER_CYCLES = CMD_BITS / NSHIFT;
    localparam int HW = $clog2(HEADER_CYCLES) + 1;
    localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t              state;
    logic [HW-1:0]       hdr_idx;
    logic [CMD_BITS-1:0] cmd_q;
    logic                owner_q;
    logic                window;
    logic                pf_ok;
    logic                sched_win;
    logic                pf_win;
    logic                grant;

`ifdef TX_ARB_ROUND_ROBIN_EN
    logic                last_sched;

    // Remember who won last; reset state favours the scheduler next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_sched <= 1'b0;
        end else if (grant) begin
            last_sched <= sched_started;
        end
    end
`endif

    // Grant window, eligibility and winner selection.
    always_comb begin
        tx_done = (state == PAYLOAD) &&
                  (tx_counter == CW'(PAYLOAD_CYCLES - 1));
        window  = !reset && ((state == IDLE) || tx_done);
        pf_ok   = pf_valid && !sched_reserve;
`ifdef TX_ARB_ROUND_ROBIN_EN
        sched_win = sched_valid && !(pf_ok && last_sched);
        pf_win    = pf_ok && !sched_win;
`else
        sched_win = sched_valid;
        pf_win    = pf_ok && !sched_valid;
`endif
        sched_started = window && sched_win;
        pf_started    = window && pf_win;
        grant         = sched_started || pf_started;
    end

    // Message sequencer: header chunks, payload cycles, chained grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            tx_counter <= '0;
            cmd_q      <= '0;
            owner_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    hdr_idx    <= '0;
                    tx_counter <= '0;
                end
                HEADER: begin
                    if (hdr_idx == HW'(HEADER_CYCLES - 1)) begin
                        state      <= PAYLOAD;
                        hdr_idx    <= '0;
                        tx_counter <= '0;
                    end else begin
                        hdr_idx <= hdr_idx + HW'(1);
                    end
                end
                PAYLOAD: begin
                    if (tx_done) begin
                        state      <= IDLE;
                        tx_counter <= '0;
                    end else begin
                        tx_counter <= tx_counter + CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    hdr_idx    <= '0;
                    tx_counter <= '0;
                end
            endcase
            if (grant) begin
                state      <= HEADER;
                hdr_idx    <= '0;
                tx_counter <= '0;
                cmd_q      <= sched_started ? sched_cmd : pf_cmd;
                owner_q    <= sched_started;
            end
        end
    end

    // Link pins and payload consume strobes follow state and owner.
    always_comb begin
        tx_pins         = '0;
        sched_data_next = 1'b0;
        pf_data_next    = 1'b0;
        tx_active       = (state != IDLE);
        tx_owner        = owner_q;
        if (state == HEADER) begin
            tx_pins = cmd_q[int'(hdr_idx) * NSHIFT +: NSHIFT];
        end else if (state == PAYLOAD) begin
            tx_pins         = owner_q ? sched_data : pf_data;
            sched_data_next = owner_q;
            pf_data_next    = !owner_q;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomised scoreboard bench for tx_arbiter against a message-level model.
// Build with TX_ARB_ROUND_ROBIN_EN to check the alternating policy.
module tb_tx_arbiter;

    localparam int HC  = 2;
    localparam int PC  = 8;
    localparam int MSG = HC + PC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sched_valid = 1'b0;
    logic       sched_reserve = 1'b0;
    logic [3:0] sched_cmd = '0;
    logic [1:0] sched_data = '0;
    logic       pf_valid = 1'b0;
    logic [3:0] pf_cmd = '0;
    logic [1:0] pf_data = '0;
    logic       sched_started, pf_started;
    logic       sched_data_next, pf_data_next;
    logic [3:0] tx_counter;
    logic       tx_active, tx_done, tx_owner;
    logic [1:0] tx_pins;

    tx_arbiter #(.NSHIFT(2), .CMD_BITS(4), .PAYLOAD_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .sched_valid(sched_valid), .sched_reserve(sched_reserve),
        .sched_cmd(sched_cmd), .sched_data(sched_data),
        .pf_valid(pf_valid), .pf_cmd(pf_cmd), .pf_data(pf_data),
        .sched_started(sched_started), .pf_started(pf_started),
        .sched_data_next(sched_data_next), .pf_data_next(pf_data_next),
        .tx_counter(tx_counter), .tx_active(tx_active),
        .tx_done(tx_done), .tx_owner(tx_owner), .tx_pins(tx_pins)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ss, sp, dns, dnp, act, done, own;
        int         cnt;
        logic [1:0] pins;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_sgrant = 0;
    int   n_pgrant = 0;
    bit   stim_done = 0;

    bit         m_busy = 0;
    int         m_pos = 0;
    bit         m_owner = 0;
    logic [3:0] m_cmd = '0;
    bit         m_last = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit sv, input bit sr,
                        input logic [3:0] sc, input bit pv,
                        input logic [3:0] pc);
        exp_t e;
        bit done, win, gs, gp, pe;
        logic [1:0] sd, pd;
        @(posedge clk);
        #1;
        sd = 2'($urandom);
        pd = 2'($urandom);
        reset = rst; sched_valid = sv; sched_reserve = sr;
        sched_cmd = sc; sched_data = sd;
        pf_valid = pv; pf_cmd = pc; pf_data = pd;
        e = '{default: 0};
        if (rst) begin
            m_busy = 0; m_pos = 0; m_owner = 0; m_last = 0;
            q.push_back(e);
            return;
        end
        done   = m_busy && (m_pos == MSG - 1);
        e.act  = m_busy;
        e.done = done;
        e.own  = m_owner;
        e.cnt  = (m_busy && m_pos >= HC) ? m_pos - HC : 0;
        if (!m_busy) e.pins = 2'b00;
        else if (m_pos < HC) e.pins = 2'((m_cmd >> (2 * m_pos)) & 4'd3);
        else e.pins = m_owner ? sd : pd;
        e.dns = m_busy && (m_pos >= HC) && m_owner;
        e.dnp = m_busy && (m_pos >= HC) && !m_owner;
        win = !m_busy || done;
`ifdef TX_ARB_ROUND_ROBIN_EN
        pe = pv && !sr;
        if (sv && pe) begin
            gs = !m_last;
            gp = m_last;
        end else begin
            gs = sv;
            gp = pe;
        end
`else
        pe = pv && !sr && !sv;
        gs = sv;
        gp = pe;
`endif
        e.ss = win && gs;
        e.sp = win && gp;
        q.push_back(e);
        if (e.ss || e.sp) begin
            m_busy = 1; m_pos = 0; m_owner = e.ss;
            m_cmd = e.ss ? sc : pc; m_last = e.ss;
        end else if (m_busy && !done) begin
            m_pos++;
        end else begin
            m_busy = 0; m_pos = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'($urandom), 0, 4'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sched_started", sched_started, e.ss);
                chk("pf_started", pf_started, e.sp);
                chk("both_started", sched_started & pf_started, 0);
                chk("sched_data_next", sched_data_next, e.dns);
                chk("pf_data_next", pf_data_next, e.dnp);
                chk("tx_active", tx_active, e.act);
                chk("tx_done", tx_done, e.done);
                chk("tx_owner", tx_owner, e.own);
                chk("tx_counter", tx_counter, e.cnt);
                chk("tx_pins", tx_pins, e.pins);
                if (sched_started) n_sgrant++;
                if (pf_started) n_pgrant++;
            end
        end
    end

    initial begin : stimulus
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(3);
        // prefetch-only message with header 1001
        step(0, 0, 0, 4'h0, 1, 4'b1001);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 4'h0, 0, 4'($urandom));
        // simultaneous requests; prefetch stays pending
        step(0, 1, 0, 4'b0110, 1, 4'b1001);
        for (int i = 0; i < 22; i++) step(0, 0, 0, 4'($urandom), 1, 4'b1001);
        idle(12);
        // reserve blocks prefetch for five cycles
        for (int i = 0; i < 5; i++) step(0, 0, 1, 4'h0, 1, 4'b0011);
        step(0, 0, 0, 4'h0, 1, 4'b0011);
        idle(12);
        // reset at payload index 3 with scheduler request pending
        step(0, 1, 0, 4'b1100, 0, 4'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 4'h0, 0, 4'h0);
        step(1, 1, 0, 4'b1010, 0, 4'h0);
        step(0, 1, 0, 4'b1010, 0, 4'h0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 4'($urandom), 0, 4'h0);
        // command changes during header are ignored
        step(0, 1, 0, 4'b0110, 0, 4'h0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 4'($urandom), 0, 4'h0);
        // both requesters continuously valid
        for (int i = 0; i < 42; i++) step(0, 1, 0, 4'($urandom), 1, 4'($urandom));
        idle(12);
        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 4'($urandom),
                 $urandom_range(0, 2) == 0,
                 4'($urandom));
        end
        idle(12);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        chk("sched_grants_seen", (n_sgrant > 0) ? 1 : 0, 1);
        chk("pf_grants_seen", (n_pgrant > 0) ? 1 : 0, 1);
        stim_done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        if (!stim_done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameters: NSHIFT, default 2, link bits per cycle; CMD_BITS, default 4, header command width (multiple of NSHIFT); PAYLOAD_CYCLES, default 8, payload cycles per message.
REQ-002 SHALL have ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- sched_valid  in  1  scheduler command request.
- sched_reserve  in  1  scheduler will need link; blocks new prefetch grants.
- sched_cmd  in  CMD_BITS  scheduler header.
- sched_data  in  NSHIFT  scheduler payload.
- pf_valid  in  1  prefetcher request.
- pf_cmd  in  CMD_BITS  prefetch header.
- pf_data  in  NSHIFT  prefetch payload.
- sched_started, pf_started  out  1  grant pulses.
- sched_data_next, pf_data_next  out  1  payload consumed this cycle.
- tx_counter  out  $clog2(PAYLOAD_CYCLES)+1  payload cycle index.
- tx_active  out  1  message in progress.
- tx_done  out  1  last payload cycle.
- tx_owner  out  1  1 = scheduler owns current message.
- tx_pins  out  NSHIFT  serial link.

Function
REQ-003 SHALL implement states IDLE, HEADER, PAYLOAD; HEADER_CYCLES = CMD_BITS/NSHIFT.
REQ-004 SHALL make a grant only in IDLE or in the tx_done cycle.
REQ-005 SHALL, at a grant, pulse the winner's *_started combinationally that cycle, latch its cmd and owner, and enter HEADER next cycle with the header index at 0.
REQ-006 SHALL use fixed priority: scheduler wins over prefetch.
REQ-007 SHALL not grant prefetch while sched_reserve or sched_valid is high.
REQ-008 SHALL, in HEADER, drive tx_pins with latched cmd chunk [i*NSHIFT +: NSHIFT] at header index i (LSB chunk first), then enter PAYLOAD after HEADER_CYCLES cycles.
REQ-009 SHALL, in PAYLOAD, drive tx_pins combinationally from the owner's *_data and assert the owner's *_data_next every payload cycle.
REQ-010 SHALL hold tx_counter at 0 outside PAYLOAD and count 0..PAYLOAD_CYCLES-1 in PAYLOAD.
REQ-011 SHALL assert tx_done when tx_counter == PAYLOAD_CYCLES-1.
REQ-012 SHALL, on a grant in the tx_done cycle, go directly to HEADER with no idle gap; otherwise return to IDLE.
REQ-013 SHALL drive tx_pins = 0 in IDLE.
REQ-014 SHALL assert tx_active in HEADER and PAYLOAD only.
REQ-015 SHALL ignore requester cmd changes after the grant; only latched values are used.
REQ-016 SHALL never assert both *_started or both *_data_next in the same cycle.

Reset
REQ-017 SHALL, on reset assertion at any time including mid-message, immediately enter IDLE with tx_pins=0, tx_counter=0, tx_active=0, tx_done=0, tx_owner=0, and all pulses low.
REQ-018 SHALL not produce tx_done for a message aborted by reset.

Configuration
REQ-019 SHALL support macro TX_ARB_ROUND_ROBIN_EN.
REQ-020 SHALL, with TX_ARB_ROUND_ROBIN_EN defined, give priority to the requester not granted last whenever both are eligible; sched_reserve still blocks prefetch; last-grant state resets to prefetch, so the scheduler wins first.
REQ-021 SHALL, with TX_ARB_ROUND_ROBIN_EN undefined, use the fixed priority of REQ-006.

Verification
REQ-022 Prefetch only: pf_valid=1, pf_cmd=4'b1001 in IDLE -> pf_started that cycle; tx_pins 01 then 10; then 8 pf_data cycles; tx_done at tx_counter=7.
REQ-023 Simultaneous requests: sched_cmd=4'b0110, pf_valid=1 -> sched_started, tx_owner=1; pf_started in the sched tx_done cycle; next HEADER starts with no gap.
REQ-024 sched_reserve=1, sched_valid=0, pf_valid=1 for 5 cycles -> no grant, tx_pins=0; reserve drops -> pf_started the same cycle.
REQ-025 Reset pulse at tx_counter=3 -> next cycle IDLE, tx_pins=0, no tx_done; a pending request is granted after reset release.
REQ-026 TX_ARB_ROUND_ROBIN_EN defined, both valid continuously -> grants alternate sched, pf, sched, pf, with back-to-back 10-cycle messages.
REQ-027 sched_cmd changed mid-HEADER -> tx_pins keep showing the latched header.
